// File: rtl/math_round_controller.sv
// rtl/math_round_controller.sv - timed binary-addition round controller fed by a 4-bit random generator
//
// Purpose: requests two operands from the random generator (enable_o pulses),
// captures them, then runs a timed round in which the player enters the sum.
// Judges each answer and keeps a saturating score over ROUNDS rounds.
//
// Optional feature macro: STREAK_BONUS_EN (adds streak counter, bonus points
// and the streak_active_o port).
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   start_i         one-cycle pulse, starts/restarts a game (IDLE/OVER only)
//   submit_i        one-cycle pulse, commits answer_i
//   tick_i          one-cycle 1 Hz enable
//   answer_i[4:0]   player's answer
//   number_i[3:0]   registered output of the random generator
//   enable_o        generator request, decoded from state only
//   operand_a_o     first captured operand
//   operand_b_o     second captured operand
//   time_left_o     seconds remaining in the round
//   score_o         saturating score
//   round_o         zero-based round index
//   correct_o       showing a correct result
//   wrong_o         showing a wrong or timed-out result
//   timed_out_o     showing a timed-out result
//   game_over_o     high in OVER
//   streak_active_o streak >= 2 (STREAK_BONUS_EN only)
module math_round_controller #(
  parameter int unsigned ROUNDS     = 8,
  parameter int unsigned TIME_LIMIT = 9,
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       submit_i,
  input  logic       tick_i,
  input  logic [4:0] answer_i,
  input  logic [3:0] number_i,
  output logic       enable_o,
  output logic [3:0] operand_a_o,
  output logic [3:0] operand_b_o,
  output logic [3:0] time_left_o,
  output logic [7:0] score_o,
  output logic [3:0] round_o,
  output logic       correct_o,
  output logic       wrong_o,
  output logic       timed_out_o,
  output logic       game_over_o
`ifdef STREAK_BONUS_EN
  ,
  output logic       streak_active_o
`endif
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_REQ_A  = 4'd1;
  localparam logic [3:0] S_CAP_A  = 4'd2;
  localparam logic [3:0] S_GAP    = 4'd3;
  localparam logic [3:0] S_REQ_B  = 4'd4;
  localparam logic [3:0] S_CAP_B  = 4'd5;
  localparam logic [3:0] S_PLAY   = 4'd6;
  localparam logic [3:0] S_RESULT = 4'd7;
  localparam logic [3:0] S_OVER   = 4'd8;

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [3:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    op_a_q, op_a_d;
  logic [3:0]    op_b_q, op_b_d;
  logic [3:0]    time_left_q, time_left_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    round_q, round_d;
  logic          correct_q, correct_d;
  logic          wrong_q, wrong_d;
  logic          timed_out_q, timed_out_d;

  logic [4:0]    sum;
  logic [1:0]    score_inc;
  logic [8:0]    score_add;
  logic [7:0]    score_sat;

`ifdef STREAK_BONUS_EN
  logic [1:0]    streak_q, streak_d;
  // Bonus applies when the streak was already >= 2 before this answer.
  assign score_inc = streak_q[1] ? 2'd2 : 2'd1;
`else
  assign score_inc = 2'd1;
`endif

  // Full 5-bit sum so 15+15=30 compares without truncation.
  assign sum       = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign score_add = {1'b0, score_q} + {7'b0, score_inc};
  assign score_sat = score_add[8] ? 8'hFF : score_add[7:0];

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    round_d     = round_q;
    correct_d   = correct_q;
    wrong_d     = wrong_q;
    timed_out_d = timed_out_q;
`ifdef STREAK_BONUS_EN
    streak_d    = streak_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_i) begin
          state_d = S_REQ_A;
          score_d = 8'd0;
          round_d = 4'd0;
`ifdef STREAK_BONUS_EN
          streak_d = 2'd0;
`endif
        end
      end
      S_REQ_A: state_d = S_CAP_A;
      S_CAP_A: begin
        // Generator updated number_i on the edge that ended REQ_A.
        op_a_d  = number_i;
        gap_d   = GW'(GAP_CYCLES);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = S_REQ_B;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_REQ_B: state_d = S_CAP_B;
      S_CAP_B: begin
        op_b_d      = number_i;
        time_left_d = 4'(TIME_LIMIT);
        state_d     = S_PLAY;
      end
      S_PLAY: begin
        // Submit has priority over a coincident tick.
        if (submit_i) begin
          state_d = S_RESULT;
          if (answer_i == sum) begin
            correct_d = 1'b1;
            score_d   = score_sat;
`ifdef STREAK_BONUS_EN
            if (streak_q != 2'd3) streak_d = streak_q + 2'd1;
`endif
          end else begin
            wrong_d = 1'b1;
`ifdef STREAK_BONUS_EN
            streak_d = 2'd0;
`endif
          end
        end else if (tick_i) begin
          if (time_left_q <= 4'd1) begin
            time_left_d = 4'd0;
            wrong_d     = 1'b1;
            timed_out_d = 1'b1;
            state_d     = S_RESULT;
`ifdef STREAK_BONUS_EN
            streak_d    = 2'd0;
`endif
          end else begin
            time_left_d = time_left_q - 4'd1;
          end
        end
      end
      S_RESULT: begin
        if (tick_i) begin
          correct_d   = 1'b0;
          wrong_d     = 1'b0;
          timed_out_d = 1'b0;
          if (round_q == 4'(ROUNDS - 1)) begin
            state_d = S_OVER;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_REQ_A;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      op_a_q      <= 4'd0;
      op_b_q      <= 4'd0;
      time_left_q <= 4'd0;
      score_q     <= 8'd0;
      round_q     <= 4'd0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      timed_out_q <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak_q    <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      round_q     <= round_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      timed_out_q <= timed_out_d;
`ifdef STREAK_BONUS_EN
      streak_q    <= streak_d;
`endif
    end
  end

  // Decoded from the state register so reset drops an in-flight request at once.
  assign enable_o    = (state_q == S_REQ_A) || (state_q == S_REQ_B);
  assign game_over_o = (state_q == S_OVER);
  assign operand_a_o = op_a_q;
  assign operand_b_o = op_b_q;
  assign time_left_o = time_left_q;
  assign score_o     = score_q;
  assign round_o     = round_q;
  assign correct_o   = correct_q;
  assign wrong_o     = wrong_q;
  assign timed_out_o = timed_out_q;
`ifdef STREAK_BONUS_EN
  assign streak_active_o = streak_q[1];
`endif

endmodule

// File: tb/tb_math_round_controller.sv
// tb/tb_math_round_controller.sv - self-checking bench for math_round_controller
module tb_math_round_controller;

  localparam int ROUNDS = 8;
  localparam int TL     = 9;
  localparam int GAP    = 3;
`ifdef STREAK_BONUS_EN
  localparam bit BONUS  = 1'b1;
`else
  localparam bit BONUS  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, submit, tick;
  logic [4:0] answer;
  logic [3:0] number;
  logic       enable_o;
  logic [3:0] operand_a_o, operand_b_o, time_left_o, round_o;
  logic [7:0] score_o;
  logic       correct_o, wrong_o, timed_out_o, game_over_o;
`ifdef STREAK_BONUS_EN
  logic       streak_active_o;
`endif

  always #5 clk = ~clk;

  math_round_controller #(.ROUNDS(ROUNDS), .TIME_LIMIT(TL), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .submit_i(submit), .tick_i(tick),
    .answer_i(answer), .number_i(number), .enable_o(enable_o),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .time_left_o(time_left_o),
    .score_o(score_o), .round_o(round_o), .correct_o(correct_o), .wrong_o(wrong_o),
    .timed_out_o(timed_out_o), .game_over_o(game_over_o)
`ifdef STREAK_BONUS_EN
    , .streak_active_o(streak_active_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_score, m_round, m_streak, m_a, m_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic new_game();
    m_score = 0; m_round = 0; m_streak = 0;
    pulse_start();
    chk("start_enable", enable_o, 1);
    chk("start_score", score_o, 0);
    chk("start_round", round_o, 0);
    chk("start_gameover", game_over_o, 0);
  endtask

  // Acts as the generator: presents a/b while the request is up; checks pulse spacing.
  task automatic fetch(input int a, input int b);
    int n;
    n = 0;
    while (enable_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk("req_a_seen", enable_o, 1);
    number = 4'(a);
    @(negedge clk);
    n = 1;
    while (enable_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk("req_spacing", n, GAP + 2);
    number = 4'(b);
    @(negedge clk);
    chk("req_b_single", enable_o, 0);
    @(negedge clk);
    m_a = a; m_b = b;
    chk("op_a", operand_a_o, a);
    chk("op_b", operand_b_o, b);
    chk("tl_load", time_left_o, TL);
  endtask

  task automatic model_answer(input int ans, output bit ok);
    int inc;
    ok = (ans == m_a + m_b);
    if (ok) begin
      inc = (BONUS && m_streak >= 2) ? 2 : 1;
      m_score = (m_score + inc > 255) ? 255 : m_score + inc;
      m_streak = (m_streak >= 3) ? 3 : m_streak + 1;
    end else begin
      m_streak = 0;
    end
  endtask

  // mode 0: plain submit (plus ignored-input probes); 1: timeout; 2: submit+tick at TimeLeft=1
  task automatic do_round(input int a, input int b, input int ans, input int mode);
    bit ok;
    fetch(a, b);
    if (mode == 1) begin
      for (int i = 1; i <= TL; i++) begin
        do_tick();
        chk("to_tl", time_left_o, TL - i);
        chk("to_wrong", wrong_o, (i == TL) ? 1 : 0);
        chk("to_flag", timed_out_o, (i == TL) ? 1 : 0);
      end
      m_streak = 0;
      chk("to_correct", correct_o, 0);
      chk("to_score", score_o, m_score);
    end else begin
      if (mode == 0) begin
        pulse_start();
        chk("play_start_ign", enable_o, 0);
      end else begin
        for (int i = 1; i < TL; i++) do_tick();
        chk("tl_at_one", time_left_o, 1);
      end
      @(negedge clk);
      answer = 5'(ans); submit = 1'b1; tick = (mode == 2);
      @(negedge clk);
      submit = 1'b0; tick = 1'b0;
      model_answer(ans, ok);
      chk("res_correct", correct_o, ok);
      chk("res_wrong", wrong_o, !ok);
      chk("res_timeout", timed_out_o, 0);
      chk("res_score", score_o, m_score);
      chk("res_tl", time_left_o, (mode == 2) ? 1 : TL);
`ifdef STREAK_BONUS_EN
      chk("streak_act", streak_active_o, m_streak >= 2);
`endif
      if (mode == 0) begin
        @(negedge clk);
        answer = ~answer; submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        chk("res_submit_ign", correct_o, ok);
        chk("res_score_hold", score_o, m_score);
      end
    end
    do_tick();
    chk("clr_correct", correct_o, 0);
    chk("clr_wrong", wrong_o, 0);
    if (m_round == ROUNDS - 1) begin
      chk("over_flag", game_over_o, 1);
      chk("over_enable", enable_o, 0);
    end else begin
      m_round++;
      chk("next_enable", enable_o, 1);
    end
    chk("round_idx", round_o, m_round);
  endtask

  initial begin
    int a, b, ans;
    rst_n = 1'b0; start = 1'b0; submit = 1'b0; tick = 1'b0; answer = '0; number = '0;
    repeat (2) @(negedge clk);
    chk("rst_enable", enable_o, 0);
    chk("rst_score", score_o, 0);
    chk("rst_flags", {correct_o, wrong_o, timed_out_o, game_over_o}, 0);
    chk("rst_ops", {operand_a_o, operand_b_o, time_left_o, round_o}, 0);
    rst_n = 1'b1;
    // Submit/tick in IDLE must do nothing.
    @(negedge clk); submit = 1'b1; tick = 1'b1;
    @(negedge clk); submit = 1'b0; tick = 1'b0;
    chk("idle_ign", {enable_o, correct_o, wrong_o}, 0);

    // Game 1: directed and random mix
    new_game();
    do_round(5, 9, 14, 0);
    do_round(15, 15, 30, 0);
    a = $urandom_range(0, 15); b = $urandom_range(0, 15);
    do_round(a, b, (a + b + 1 + $urandom_range(0, 29)) % 31, 0);
    do_round($urandom_range(0, 15), $urandom_range(0, 15), 0, 1);
    a = $urandom_range(0, 15); b = $urandom_range(0, 15);
    do_round(a, b, a + b, 2);
    for (int r = 5; r < ROUNDS; r++) begin
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      ans = ($urandom_range(0, 1) == 1) ? a + b : $urandom_range(0, 31);
      do_round(a, b, ans, 0);
    end
    repeat (3) @(negedge clk);
    chk("over_hold", game_over_o, 1);
    chk("over_score", score_o, m_score);

    // Game 2: all correct, including zero operands
    new_game();
    do_round(0, 0, 0, 0);
    for (int r = 1; r < ROUNDS; r++) begin
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      do_round(a, b, a + b, 0);
    end
    chk("g2_score", score_o, BONUS ? 14 : 8);
    chk("g2_round", round_o, ROUNDS - 1);

    // Game 3: streak, then asynchronous reset mid-round
    new_game();
    for (int r = 0; r < 3; r++) begin
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      do_round(a, b, a + b, 0);
    end
    chk("g3_score", score_o, BONUS ? 4 : 3);
    fetch(7, 3);
    repeat (5) do_tick();
    chk("pre_rst_tl", time_left_o, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ops", {operand_a_o, operand_b_o, time_left_o, round_o}, 0);
    chk("arst_score", score_o, 0);
    chk("arst_flags", {enable_o, correct_o, wrong_o, timed_out_o, game_over_o}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); answer = 5'd10; submit = 1'b1;
    @(negedge clk); submit = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ign", {enable_o, correct_o, wrong_o, score_o}, 0);
    new_game();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
